// File: rtl/vga_depth_adapter.sv
// Video output stage: per-channel colour depth conversion, two-stage pixel pipeline, sync normalisation
// and line-length / mode-stability measurement. Define VGA_DEPTH_ADAPTER_POLDET_EN for input sync polarity detection.
module vga_depth_adapter #(
   parameter int IN_W       = 6,
   parameter int OUT_W      = 8,
   parameter bit HS_POL_OUT = 1'b0,
   parameter bit VS_POL_OUT = 1'b0,
   parameter int LEN_W      = 12
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             ce_pix,
   input  logic [IN_W-1:0]  in_r,
   input  logic [IN_W-1:0]  in_g,
   input  logic [IN_W-1:0]  in_b,
   input  logic             in_hs,
   input  logic             in_vs,
   output logic [OUT_W-1:0] out_r,
   output logic [OUT_W-1:0] out_g,
   output logic [OUT_W-1:0] out_b,
   output logic             out_hs,
   output logic             out_vs,
   output logic             hs_pol,
   output logic             vs_pol,
   output logic [LEN_W-1:0] line_len,
   output logic             mode_stable
);

   localparam logic [LEN_W-1:0] LEN_MAX = '1;

   function automatic logic [LEN_W-1:0] sat_inc(input logic [LEN_W-1:0] v);
      return (v == LEN_MAX) ? v : v + LEN_W'(1);
   endfunction

   logic [IN_W-1:0]  s1_r, s1_g, s1_b;
   logic             s1_hs, s1_vs;
   logic             hs_prev, vs_prev;
   logic             hs_rise, vs_rise;
   logic [OUT_W-1:0] exp_r, exp_g, exp_b;
   logic             hs_pol_q, vs_pol_q;
   logic             hs_active, vs_active;
   logic [LEN_W-1:0] new_len;
   logic [LEN_W-1:0] line_len_q;
   logic [1:0]       stab_cnt;
   logic             vs_seen;

   assign hs_rise = s1_hs & ~hs_prev;
   assign vs_rise = s1_vs & ~vs_prev;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_r    <= '0;
         s1_g    <= '0;
         s1_b    <= '0;
         s1_hs   <= 1'b0;
         s1_vs   <= 1'b0;
         hs_prev <= 1'b0;
         vs_prev <= 1'b0;
      end else if (ce_pix) begin
         s1_r    <= in_r;
         s1_g    <= in_g;
         s1_b    <= in_b;
         s1_hs   <= in_hs;
         s1_vs   <= in_vs;
         hs_prev <= s1_hs;
         vs_prev <= s1_vs;
      end
   end

   // Widening replicates the channel MSBs into the new LSBs so full scale maps to full scale.
   generate
      if (OUT_W > IN_W) begin : g_widen
         assign exp_r = {s1_r, s1_r[IN_W-1 -: OUT_W-IN_W]};
         assign exp_g = {s1_g, s1_g[IN_W-1 -: OUT_W-IN_W]};
         assign exp_b = {s1_b, s1_b[IN_W-1 -: OUT_W-IN_W]};
      end else if (OUT_W == IN_W) begin : g_pass
         assign exp_r = s1_r;
         assign exp_g = s1_g;
         assign exp_b = s1_b;
      end else begin : g_narrow
         assign exp_r = s1_r[IN_W-1 -: OUT_W];
         assign exp_g = s1_g[IN_W-1 -: OUT_W];
         assign exp_b = s1_b[IN_W-1 -: OUT_W];
      end
   endgenerate

   assign hs_active = s1_hs ~^ hs_pol_q;
   assign vs_active = s1_vs ~^ vs_pol_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         out_r  <= '0;
         out_g  <= '0;
         out_b  <= '0;
         out_hs <= ~HS_POL_OUT;
         out_vs <= ~VS_POL_OUT;
      end else if (ce_pix) begin
         out_r  <= exp_r;
         out_g  <= exp_g;
         out_b  <= exp_b;
         out_hs <= hs_active ? HS_POL_OUT : ~HS_POL_OUT;
         out_vs <= vs_active ? VS_POL_OUT : ~VS_POL_OUT;
      end
   end

`ifdef VGA_DEPTH_ADAPTER_POLDET_EN
   logic [LEN_W-1:0] hi_cnt, lo_cnt;
   logic [LEN_W-1:0] vhi_cnt, vlo_cnt;
   logic [LEN_W-1:0] vhi_next, vlo_next;
   logic [LEN_W:0]   len_sum;

   assign len_sum = {1'b0, hi_cnt} + {1'b0, lo_cnt};
   assign new_len = len_sum[LEN_W] ? LEN_MAX : len_sum[LEN_W-1:0];

   // The sync is taken to be whichever phase of the line is shorter.
   always_ff @(posedge clk) begin
      if (reset) begin
         hi_cnt   <= '0;
         lo_cnt   <= '0;
         hs_pol_q <= 1'b0;
      end else if (ce_pix) begin
         if (hs_rise) begin
            hs_pol_q <= (hi_cnt < lo_cnt);
            hi_cnt   <= LEN_W'(1);
            lo_cnt   <= '0;
         end else if (s1_hs) begin
            hi_cnt <= sat_inc(hi_cnt);
         end else begin
            lo_cnt <= sat_inc(lo_cnt);
         end
      end
   end

   // A line ending together with the frame is counted in the frame that is ending.
   always_comb begin
      vhi_next = vhi_cnt;
      vlo_next = vlo_cnt;
      if (hs_rise) begin
         if (s1_vs) vhi_next = sat_inc(vhi_cnt);
         else       vlo_next = sat_inc(vlo_cnt);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         vhi_cnt  <= '0;
         vlo_cnt  <= '0;
         vs_pol_q <= 1'b0;
      end else if (ce_pix) begin
         if (vs_rise) begin
            if ((vhi_next != '0) || (vlo_next != '0)) vs_pol_q <= (vhi_next < vlo_next);
            vhi_cnt <= '0;
            vlo_cnt <= '0;
         end else begin
            vhi_cnt <= vhi_next;
            vlo_cnt <= vlo_next;
         end
      end
   end
`else
   logic [LEN_W-1:0] line_cnt;

   assign new_len  = line_cnt;
   assign hs_pol_q = 1'b0;
   assign vs_pol_q = 1'b0;

   always_ff @(posedge clk) begin
      if (reset) begin
         line_cnt <= '0;
      end else if (ce_pix) begin
         if (hs_rise) line_cnt <= LEN_W'(1);
         else         line_cnt <= sat_inc(line_cnt);
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         line_len_q <= '0;
         stab_cnt   <= '0;
         vs_seen    <= 1'b0;
      end else if (ce_pix) begin
         if (hs_rise) begin
            line_len_q <= new_len;
            if (new_len == line_len_q) stab_cnt <= (stab_cnt == 2'd3) ? stab_cnt : stab_cnt + 2'd1;
            else                       stab_cnt <= '0;
         end
         if (vs_rise) vs_seen <= 1'b1;
      end
   end

   assign hs_pol      = hs_pol_q;
   assign vs_pol      = vs_pol_q;
   assign line_len    = line_len_q;
   assign mode_stable = (stab_cnt == 2'd3) && vs_seen;

endmodule
